// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall bus width, stall vectors,
// reset level, controller states and the multicycle length helper.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;
    typedef logic [STALL_W-1:0] stall_bus_t;

    // Each vector freezes its own stage and everything upstream of it
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_IF   = 6'b000011;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;
    localparam stall_bus_t STALL_MEM  = 6'b011111;
    localparam stall_bus_t STALL_ALL  = 6'b111111;

    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MC    = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // A zero length still costs the start cycle
    function automatic logic [5:0] eff_len(input logic [5:0] len);
        return (len == 6'd0) ? 6'd1 : len;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/redirect requests from the pipeline and the resulting control outputs.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_mem;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_len;
    logic        excp_valid;
    logic        eret_valid;
    logic [31:0] epc;

    stall_bus_t  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
    logic        mc_done;

    modport master (
        output stallreq_if, stallreq_id, stallreq_mem, ex_mc_start, ex_mc_len,
               excp_valid, eret_valid, epc,
        input  stall, flush, new_pc, mc_busy, mc_done
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_mem, ex_mc_start, ex_mc_len,
               excp_valid, eret_valid, epc,
        output stall, flush, new_pc, mc_busy, mc_done
    );

endinterface

// File: rtl/pipe_ctrl_mc_timer.sv
// Down-counter for EX multicycle ops; last flags the final stalled cycle.
module mc_timer
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       dec,
    output logic       last
);

    logic [5:0] count;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != 6'd0)
            count <= count - 6'd1;
    end

    assign last = (count == 6'd1);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: priority stall selection, EX multicycle
// tracking and one-cycle exception/eret redirect.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXCP_VEC = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    state_e      state, state_nxt;
    logic [31:0] redir_pc, redir_nxt;

    stall_bus_t  stall_c;
    logic        flush_c;
    logic [31:0] new_pc_c;
    logic        mc_done_c;
    logic        mc_busy_c;

    logic        redirect;
    logic        mc_start;
    logic        ex_stall;
    logic [5:0]  mc_len_eff;
    logic        mc_load, mc_dec, mc_clr, mc_last;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state    <= ST_RUN;
            redir_pc <= '0;
        end else begin
            state    <= state_nxt;
            redir_pc <= redir_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        redir_nxt  = redir_pc;
        stall_c    = STALL_NONE;
        flush_c    = 1'b0;
        new_pc_c   = '0;
        mc_done_c  = 1'b0;
        mc_busy_c  = 1'b0;
        mc_load    = 1'b0;
        mc_dec     = 1'b0;
        mc_clr     = 1'b0;
        ex_stall   = 1'b0;
        mc_len_eff = eff_len(bus.ex_mc_len);
        redirect   = (state != ST_FLUSH) && (bus.excp_valid || bus.eret_valid);
        mc_start   = (state == ST_RUN) && bus.ex_mc_start;

        // Outputs held quiet during reset so an aborted op leaves no pulse
        if (rst != RST_ENABLE) begin
            mc_busy_c = (state == ST_MC);
            case (state)
                ST_FLUSH: begin
                    flush_c   = 1'b1;
                    new_pc_c  = redir_pc;
                    state_nxt = ST_RUN;
                end
                default: begin
                    if (redirect) begin
                        stall_c   = STALL_ALL;
                        redir_nxt = bus.excp_valid ? EXCP_VEC : bus.epc;
                        mc_clr    = 1'b1;
                        state_nxt = ST_FLUSH;
                    end else begin
                        ex_stall = mc_start || (state == ST_MC);
                        if (bus.stallreq_mem)     stall_c = STALL_MEM;
                        else if (ex_stall)        stall_c = STALL_EX;
                        else if (bus.stallreq_id) stall_c = STALL_ID;
                        else if (bus.stallreq_if) stall_c = STALL_IF;

                        // The count keeps running even when MEM owns the stall vector
                        if (state == ST_MC) begin
                            mc_dec = 1'b1;
                            if (mc_last) begin
                                mc_done_c = 1'b1;
                                state_nxt = ST_RUN;
                            end
                        end else if (mc_start) begin
                            if (mc_len_eff > 6'd1) begin
                                mc_load   = 1'b1;
                                state_nxt = ST_MC;
                            end else begin
                                mc_done_c = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    mc_timer u_mc_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (mc_clr),
        .load     (mc_load),
        .load_val (mc_len_eff - 6'd1),
        .dec      (mc_dec),
        .last     (mc_last)
    );

    assign bus.stall   = stall_c;
    assign bus.flush   = flush_c;
    assign bus.new_pc  = new_pc_c;
    assign bus.mc_busy = mc_busy_c;
    assign bus.mc_done = mc_done_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle input vectors with hand-computed outputs.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.EXCP_VEC(32'h0000_0020)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r, mem, id, ifs, st;
        logic [5:0]  len;
        logic        ex, er;
        logic [31:0] epc;
    } vec_t;

    function automatic vec_t V(logic r, logic mem, logic id, logic ifs, logic st,
                               logic [5:0] len, logic ex, logic er, logic [31:0] epc);
        vec_t v;
        v.r = r; v.mem = mem; v.id = id; v.ifs = ifs; v.st = st;
        v.len = len; v.ex = ex; v.er = er; v.epc = epc;
        return v;
    endfunction

    // {stall, flush, mc_busy, mc_done, new_pc}
    function automatic logic [40:0] O(logic [5:0] s, logic f, logic b, logic d, logic [31:0] pc);
        return {s, f, b, d, pc};
    endfunction

    function automatic logic [40:0] obs();
        return {bus.stall, bus.flush, bus.mc_busy, bus.mc_done, bus.new_pc};
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst              = v.r;
        bus.stallreq_mem = v.mem;
        bus.stallreq_id  = v.id;
        bus.stallreq_if  = v.ifs;
        bus.ex_mc_start  = v.st;
        bus.ex_mc_len    = v.len;
        bus.excp_valid   = v.ex;
        bus.eret_valid   = v.er;
        bus.epc          = v.epc;
        #1;
    endtask

    localparam vec_t IDLE = 50'd0;
    localparam logic [40:0] Z = 41'd0;

    task automatic test_reset();
        vec_t s [3];
        logic [40:0] e [3];
        s = '{V(1,0,0,0,0,0,0,0,0), V(1,1,1,1,1,6'd3,0,0,0), IDLE};
        e = '{Z, Z, Z};
        for (int i = 0; i < 3; i++) begin
            apply(s[i]);
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL reset c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_priority();
        vec_t s [6];
        logic [40:0] e [6];
        s = '{V(0,0,1,1,0,0,0,0,0), V(0,0,0,1,0,0,0,0,0), V(0,1,1,1,0,0,0,0,0),
              V(0,0,1,0,0,0,0,0,0), V(0,1,0,0,0,0,0,0,0), IDLE};
        e = '{O(6'b000111,0,0,0,0), O(6'b000011,0,0,0,0), O(6'b011111,0,0,0,0),
              O(6'b000111,0,0,0,0), O(6'b011111,0,0,0,0), Z};
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL priority c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
    endtask

    // len=4, then len=1 and len=0 which finish in the start cycle
    task automatic test_mc_len();
        vec_t s [9];
        logic [40:0] e [9];
        s = '{V(0,0,0,1,1,6'd4,0,0,0), V(0,0,1,0,0,0,0,0,0), IDLE, IDLE, IDLE,
              V(0,0,0,0,1,6'd1,0,0,0), IDLE, V(0,0,0,0,1,6'd0,0,0,0), IDLE};
        e = '{O(6'b001111,0,0,0,0), O(6'b001111,0,1,0,0), O(6'b001111,0,1,0,0),
              O(6'b001111,0,1,1,0), Z,
              O(6'b001111,0,0,1,0), Z, O(6'b001111,0,0,1,0), Z};
        for (int i = 0; i < 9; i++) begin
            apply(s[i]);
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL mc_len c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
    endtask

    // len=5, MEM stall in cycle 2, a second start in cycle 3 must be ignored
    task automatic test_mc_mem();
        vec_t s [7];
        logic [40:0] e [7];
        s = '{V(0,0,0,0,1,6'd5,0,0,0), V(0,1,0,0,0,0,0,0,0), V(0,0,0,0,1,6'd2,0,0,0),
              IDLE, IDLE, IDLE, IDLE};
        e = '{O(6'b001111,0,0,0,0), O(6'b011111,0,1,0,0), O(6'b001111,0,1,0,0),
              O(6'b001111,0,1,0,0), O(6'b001111,0,1,1,0), Z, Z};
        for (int i = 0; i < 7; i++) begin
            apply(s[i]);
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL mc_mem c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
    endtask

    // exception aborts MC; requests during FLUSH are ignored
    task automatic test_excp_mc();
        vec_t s [6];
        logic [40:0] e [6];
        s = '{V(0,0,0,0,1,6'd4,0,0,0), V(0,0,0,0,0,0,1,0,0), V(0,1,1,1,1,6'd4,0,0,0),
              IDLE, IDLE, IDLE};
        e = '{O(6'b001111,0,0,0,0), O(6'b111111,0,1,0,0), O(6'b000000,1,0,0,32'h20),
              Z, Z, Z};
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL excp_mc c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
    endtask

    // eret uses registered epc; excp beats eret; excp beats a same-cycle mc start
    task automatic test_eret();
        vec_t s [9];
        logic [40:0] e [9];
        s = '{V(0,0,0,0,0,0,0,1,32'hBFC0_0100), V(0,0,0,0,0,0,0,0,32'h1234_5678), IDLE,
              V(0,0,0,0,0,0,1,1,32'hBFC0_0100), IDLE, IDLE,
              V(0,0,0,0,1,6'd4,1,0,0), IDLE, IDLE};
        e = '{O(6'b111111,0,0,0,0), O(6'b000000,1,0,0,32'hBFC0_0100), Z,
              O(6'b111111,0,0,0,0), O(6'b000000,1,0,0,32'h20), Z,
              O(6'b111111,0,0,0,0), O(6'b000000,1,0,0,32'h20), Z};
        for (int i = 0; i < 9; i++) begin
            apply(s[i]);
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL eret c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
    endtask

    // reset mid-MC and mid-FLUSH leaves no done or flush pulse
    task automatic test_rst_mid();
        vec_t s [11];
        logic [40:0] e [11];
        s = '{V(0,0,0,0,1,6'd5,0,0,0), IDLE, V(1,0,0,0,0,0,0,0,0),
              IDLE, IDLE, IDLE, IDLE, IDLE,
              V(0,0,0,0,0,0,1,0,0), V(1,0,0,0,0,0,0,0,0), IDLE};
        e = '{O(6'b001111,0,0,0,0), O(6'b001111,0,1,0,0), Z,
              Z, Z, Z, Z, Z,
              O(6'b111111,0,0,0,0), Z, Z};
        for (int i = 0; i < 11; i++) begin
            apply(s[i]);
            total++;
            if (obs() !== e[i]) begin
                bad++;
                $display("FAIL rst_mid c%0d got=%h want=%h", i, obs(), e[i]);
            end
        end
    endtask

    initial begin
        bus.stallreq_mem = 1'b0;
        bus.stallreq_id  = 1'b0;
        bus.stallreq_if  = 1'b0;
        bus.ex_mc_start  = 1'b0;
        bus.ex_mc_len    = '0;
        bus.excp_valid   = 1'b0;
        bus.eret_valid   = 1'b0;
        bus.epc          = '0;
        test_reset();
        test_priority();
        test_mc_len();
        test_mc_mem();
        test_excp_mc();
        test_eret();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter EXCP_VEC, default 32'h0000_0020, meaning exception handler PC.
REQ-002 SHALL provide clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 SHALL provide rst  input  1  reset; synchronous, active-high; clock clk.
REQ-004 SHALL provide stallreq_if  input  1  fetch not ready (instruction miss).
REQ-005 SHALL provide stallreq_id  input  1  decode load-use hazard.
REQ-006 SHALL provide stallreq_mem  input  1  memory stage not ready.
REQ-007 SHALL provide ex_mc_start  input  1  one-cycle pulse: EX began a multicycle op.
REQ-008 SHALL provide ex_mc_len  input  6  total EX stall cycles for that op; 0 is treated as 1.
REQ-009 SHALL provide excp_valid  input  1  exception raised at MEM.
REQ-010 SHALL provide eret_valid  input  1  exception return at MEM.
REQ-011 SHALL provide epc  input  32  return PC for eret.
REQ-012 SHALL provide stall  output  6  hold enables: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-013 SHALL provide flush  output  1  clear all pipeline registers to NOP.
REQ-014 SHALL provide new_pc  output  32  redirect PC, valid only while flush=1.
REQ-015 SHALL provide mc_busy  output  1  high while in MC state.
REQ-016 SHALL provide mc_done  output  1  one-cycle pulse in the final stalled cycle of a multicycle op.

Function
REQ-017 SHALL implement FSM states RUN, MC, FLUSH; reset state RUN.
REQ-018 SHALL, when excp_valid or eret_valid is high in RUN or MC, drive stall=6'b111111 that cycle, record redirect, and enter FLUSH next cycle, aborting any MC count.
REQ-019 SHALL, in FLUSH, drive flush=1, stall=0, new_pc=EXCP_VEC (excp) or registered epc (eret), for exactly one cycle, then return to RUN.
REQ-020 SHALL give excp_valid priority over eret_valid when both are high.
REQ-021 SHALL ignore all requests and ex_mc_start while in FLUSH.
REQ-022 SHALL, outside flush handling, select stall combinationally by priority: stallreq_mem 6'b011111 > EX multicycle 6'b001111 > stallreq_id 6'b000111 > stallreq_if 6'b000011 > 6'b000000.
REQ-023 SHALL, on ex_mc_start in RUN with effective length L, assert the EX stall in the start cycle; if L>1, load a 6-bit counter with L-1 and enter MC; if L=1, pulse mc_done in the start cycle and stay in RUN.
REQ-024 SHALL, in MC, assert the EX stall, decrement the counter each cycle, pulse mc_done and return to RUN when the counter reads 1.
REQ-025 SHALL keep the MC counter running while stallreq_mem overrides the stall vector.
REQ-026 SHALL ignore ex_mc_start while in MC; the count is unaffected.
REQ-027 SHALL give excp/eret precedence over a simultaneous ex_mc_start; MC is not entered.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, enter RUN, clear counter and redirect register; stall=0, flush=0, new_pc=0, mc_busy=0, mc_done=0.
REQ-029 SHALL abort an in-progress MC or FLUSH on reset mid-operation, with no mc_done or flush pulse.

Structure
REQ-030 SHALL take the StallBus width, the stall vector constants and the RstEnable level from the shared defines file.
REQ-031 SHALL contain one sub-module mc_timer (load, decrement, last-cycle flag).

Verification
REQ-032 SHALL be verified by: stallreq_id=1 and stallreq_if=1 together -> stall=6'b000111.
REQ-033 SHALL be verified by: ex_mc_start with ex_mc_len=4 -> stall=6'b001111 for 4 cycles, mc_busy for 3, mc_done in the 4th cycle.
REQ-034 SHALL be verified by: MC with len=5, stallreq_mem pulsed in cycle 2 -> stall=6'b011111 that cycle; mc_done still in cycle 5.
REQ-035 SHALL be verified by: excp_valid in cycle 2 of MC -> stall=6'b111111 that cycle, next cycle flush=1 and new_pc=32'h20, no mc_done.
REQ-036 SHALL be verified by: eret_valid with epc=32'hBFC0_0100 -> one cycle later flush=1, new_pc=32'hBFC0_0100; excp_valid with eret_valid -> new_pc=32'h20.
REQ-037 SHALL be verified by: rst during MC -> next cycle all outputs 0, mc_done never pulses.
